fpu_seq_ctrl: RTL
=================

# fpu_seq_ctrl

Step sequencer that runs a multi-cycle FPU datapath (shift/add mantissa loops, normalisation passes) for a programmed number of iterations. Accepts a start request with a step count, issues one `step_en` per active cycle, supports datapath stalls and abort, and signals completion with a one-cycle `done` pulse. Sits between the FPU operation decoder and the iterative mantissa datapath, and owns the iteration counter.

## Interface
- `CNT_W`, 4: width of step count and index; max steps = 2^CNT_W − 1.
- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `start`  in  1  request to begin a sequence; honoured only in IDLE.
- `steps`  in  CNT_W  iteration count, sampled with `start`.
- `hold`  in  1  datapath stall; freezes the sequence while high.
- `abort`  in  1  cancel the running sequence.
- `busy`  out  1  high in RUN.
- `step_en`  out  1  datapath advance strobe; RUN && !hold && !abort.
- `idx`  out  CNT_W  current step index, 0-based, registered.
- `first`  out  1  RUN && idx == 0.
- `last`  out  1  RUN && idx == steps_q − 1.
- `done`  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: if `start` && !`abort`: latch `steps` into `steps_q`; clear `idx` to 0; go to RUN if steps ≠ 0, otherwise go to DONE.
- RUN:
  - `abort` has the highest priority: go to IDLE and clear `idx`; no `done` is issued.
  - Else if `hold`: no state change and `idx` is held.
  - Else if `idx` == steps_q − 1: go to DONE.
  - Else: `idx` increments by 1.
- DONE: `done` = 1 for exactly one cycle, then go to IDLE unconditionally. `start` and `abort` are ignored in this state.
- `start` in RUN or DONE is ignored; it is not queued.
- `idx` never wraps. The terminal compare ends the sequence before the counter overflows, including at steps = 2^CNT_W − 1.
- Reset, including mid-sequence: next edge forces IDLE, `idx` = 0, `steps_q` = 0.
- Reset value of every output: `busy` = `step_en` = `first` = `last` = `done` = 0, `idx` = 0.

## Timing
- `start` sampled at edge 0 with N > 0:
  - RUN during cycles 1..N.
  - `step_en` high in each of those cycles.
  - `idx` takes the values 0..N−1.
  - `done` high in cycle N+1.
  - IDLE in cycle N+2; a new `start` is accepted at the edge ending cycle N+2.
- N = 0: `done` in cycle 1; no `step_en` is issued.
- Each cycle with `hold` high extends the RUN phase by exactly one cycle.
- `first`, `last`, `busy` and `done` are decoded from registered state and `idx`. `step_en` combinationally includes `hold` and `abort`.
- Minimum start-to-start spacing: N+2 cycles.

## Structure
- Package `fpu_seq_pkg`:
  - state enum `seq_state_t` {IDLE, RUN, DONE}.
  - default `CNT_W` constant.
- Sub-module `step_counter`: CNT_W-bit up counter.
  - Inputs: synchronous clear and enable. Uses the same `rst` convention.
  - Output: terminal flag `tc` = (count == limit), where `limit` is an input.
- `fpu_seq_ctrl` holds the FSM and `steps_q`, and instantiates one `step_counter`.

## Test plan
- Reset then `start` with `steps` = 5, no hold → `step_en` high for 5 cycles, `idx` 0,1,2,3,4, `first` at idx 0, `last` at idx 4, `done` one cycle after, `busy` low again.
- `steps` = 0 → `done` pulse the cycle after `start`, `busy` never high, `step_en` never high.
- `steps` = 15 with `hold` high at idx 3 for 2 cycles, and `start` re-asserted mid-run → idx stays 3 for 2 cycles, 17 RUN cycles total, no wrap past 14, the second `start` is ignored, exactly one `done`.
- `steps` = 8, `abort` at idx 2 → `step_en` low that cycle, IDLE next cycle, `idx` = 0, no `done`. A following `start` with `steps` = 1 completes normally.
- `rst` low at idx 6 of a 10-step run → all outputs 0 after the next edge. `start` and `abort` both high in IDLE → no sequence starts.
- Back-to-back runs: `start` held high continuously with `steps` = 3 → runs accepted every 5 cycles, with exactly one `done` per run.

Source files
------------

// File: rtl/fpu_seq_pkg.sv
// Shared types and defaults for the FPU step sequencer.
package fpu_seq_pkg;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Default width of the step count / step index.
  localparam int CNT_W_DEF = 4;

endpackage

// File: rtl/fpu_seq_ctrl_step_counter.sv
// Iteration counter for the FPU step sequencer: clearable, enabled up counter
// with a terminal flag raised when the count equals a supplied limit.
module step_counter
  import fpu_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_limit,
  output logic [CNT_W-1:0] o_count,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_count;

  // Count register: reset and clear win over the increment enable.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == i_limit);

endmodule

// File: rtl/fpu_seq_ctrl.sv
// Step sequencer for the iterative FPU mantissa datapath. Runs a programmed
// number of steps, honouring datapath stalls and abort, and pulses done once
// per completed sequence.
module fpu_seq_ctrl
  import fpu_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_steps,
  input  logic             i_hold,
  input  logic             i_abort,
  output logic             o_busy,
  output logic             o_step_en,
  output logic [CNT_W-1:0] o_idx,
  output logic             o_first,
  output logic             o_last,
  output logic             o_done
);

  seq_state_t       r_state;
  logic [CNT_W-1:0] r_steps_q;

  logic             w_run;
  logic             w_accept;
  logic             w_clr;
  logic             w_en;
  logic             w_tc;
  logic [CNT_W-1:0] w_limit;
  logic [CNT_W-1:0] w_idx;

  // The last step index is steps_q-1; only consulted while running, where
  // steps_q is guaranteed non-zero, so the wrap at steps_q==0 is harmless.
  assign w_limit  = r_steps_q - CNT_W'(1);
  assign w_run    = (r_state == RUN);
  assign w_accept = (r_state == IDLE) && i_start && !i_abort;

  // Clear on every accepted start and on abort; advance only on a real step
  // that is not the terminal one, so the index can never wrap.
  assign w_clr = w_accept || (w_run && i_abort);
  assign w_en  = w_run && !i_hold && !i_abort && !w_tc;

  step_counter #(
    .CNT_W (CNT_W)
  ) u_step_counter (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_clr),
    .i_en    (w_en),
    .i_limit (w_limit),
    .o_count (w_idx),
    .o_tc    (w_tc)
  );

  // Sequencer FSM and captured step count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_steps_q <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_steps_q <= i_steps;
            r_state   <= (i_steps != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          if (i_abort) begin
            r_state <= IDLE;
          end else if (!i_hold && w_tc) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_busy    = w_run;
  assign o_step_en = w_run && !i_hold && !i_abort;
  assign o_idx     = w_idx;
  assign o_first   = w_run && (w_idx == '0);
  assign o_last    = w_run && w_tc;
  assign o_done    = (r_state == DONE);

endmodule
